// File: rtl/sr_pulse_driver.sv
// Valid/ready command driver for an active-low SR NAND latch: one pulse per command, then dead time.
// Define SR_VERIFY_EN to add synchronized latch Q feedback and a sticky mismatch flag (ports q, err).
module sr_pulse_driver #(
    parameter int PULSE_W = 4,
    parameter int DEAD_T  = 2,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic state_q
`ifdef SR_VERIFY_EN
    ,
    input  logic q,
    output logic err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] DEAD_LOAD  = CW'(DEAD_T - 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          dir_reg;
    logic          cnt_zero;

    assign cnt_zero  = (cnt_reg == '0);
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    // Outputs are driven from the same edge that changes state, so s_n/r_n never glitch low together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            s_n       <= 1'b1;
            r_n       <= 1'b1;
            state_q   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_reg   <= cmd_set;
                        cnt_reg   <= PULSE_LOAD;
                        state_reg <= PULSE;
                        s_n       <= !cmd_set;
                        r_n       <= cmd_set;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        s_n       <= 1'b1;
                        r_n       <= 1'b1;
                        state_q   <= dir_reg;
                        cnt_reg   <= DEAD_LOAD;
                        state_reg <= DEAD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DEAD: begin
                    if (cnt_zero) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    s_n       <= 1'b1;
                    r_n       <= 1'b1;
                end
            endcase
        end
    end

`ifdef SR_VERIFY_EN
    logic q_meta_reg;
    logic q_sync_reg;

    // The latch is asynchronous to clk; compare only after the dead time has let Q settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_meta_reg <= 1'b0;
            q_sync_reg <= 1'b0;
            err        <= 1'b0;
        end else begin
            q_meta_reg <= q;
            q_sync_reg <= q_meta_reg;
            if (state_reg == DEAD && cnt_zero && (q_sync_reg != state_q)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed-vector bench for sr_pulse_driver: default instance plus a short-pulse instance.
// With SR_VERIFY_EN defined, behavioural latch models close the Q feedback loop.
`timescale 1ns/1ps
module tb_sr_pulse_driver;

`ifdef SR_VERIFY_EN
    localparam int D1 = 2;
`else
    localparam int D1 = 1;
`endif
    localparam int P1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid0, cmd_set0, rdy0, s_n0, r_n0, busy0, sq0;
    logic cmd_valid1, cmd_set1, rdy1, s_n1, r_n1, busy1, sq1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

`ifdef SR_VERIFY_EN
    logic lq0 = 1'b0, lq1 = 1'b0, q_force = 1'b0;
    logic q0, q1, err0, err1;
    always @(negedge s_n0) lq0 = 1'b1;
    always @(negedge r_n0) lq0 = 1'b0;
    always @(negedge s_n1) lq1 = 1'b1;
    always @(negedge r_n1) lq1 = 1'b0;
    assign q0 = q_force ? 1'b0 : lq0;
    assign q1 = lq1;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_pulse_driver dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_set(cmd_set0),
        .cmd_ready(rdy0), .s_n(s_n0), .r_n(r_n0), .busy(busy0), .state_q(sq0)
`ifdef SR_VERIFY_EN
        , .q(q0), .err(err0)
`endif
    );

    sr_pulse_driver #(.PULSE_W(P1), .DEAD_T(D1), .CW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_set(cmd_set1),
        .cmd_ready(rdy1), .s_n(s_n1), .r_n(r_n1), .busy(busy1), .state_q(sq1)
`ifdef SR_VERIFY_EN
        , .q(q1), .err(err1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0();
        for (int i = 0; i < 50 && !rdy0; i++) tick();
        check_eq("idle_reached", rdy0, 1'b1);
    endtask

    task automatic issue0(input logic s);
        cmd_valid0 = 1'b1;
        cmd_set0   = s;
        tick();
        cmd_valid0 = 1'b0;
    endtask

    // Per-cycle invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((s_n0 | r_n0) !== 1'b1) check_eq("never_both_low0", s_n0 | r_n0, 1'b1);
            if ((s_n1 | r_n1) !== 1'b1) check_eq("never_both_low1", s_n1 | r_n1, 1'b1);
            if (busy0 !== !rdy0) check_eq("busy_not_ready0", busy0, !rdy0);
            if (busy1 !== !rdy1) check_eq("busy_not_ready1", busy1, !rdy1);
        end
    end

    initial begin
        int s_low, r_low, rdy_low, ts, tr, falls, t1, t2;
        logic prev_s, prev_r;

        rst_n = 1'b0; cmd_valid0 = 1'b0; cmd_set0 = 1'b0; cmd_valid1 = 1'b0; cmd_set1 = 1'b0;
        tick(); tick();
        mon_en = 1'b1;
        check_eq("rst_ready", rdy0, 1'b1);
        check_eq("rst_s_n", s_n0, 1'b1);
        check_eq("rst_r_n", r_n0, 1'b1);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_state_q", sq0, 1'b0);
`ifdef SR_VERIFY_EN
        check_eq("rst_err", err0, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Single set: 4 cycles low, 6 cycles not ready, state_q updates at release edge.
        issue0(1'b1);
        s_low = 0; r_low = 0; rdy_low = 0;
        for (int i = 0; i < 10; i++) begin
            if (!s_n0) s_low++;
            if (!r_n0) r_low++;
            if (!rdy0) rdy_low++;
            if (i == 3) check_eq("set_state_q_during_pulse", sq0, 1'b0);
            if (i == 4) check_eq("set_state_q_at_release", sq0, 1'b1);
            tick();
        end
        check_eq("set_s_low_cycles", s_low, 4);
        check_eq("set_r_low_cycles", r_low, 0);
        check_eq("set_ready_low_cycles", rdy_low, 6);

        // Back-to-back: valid held, set then reset, pulses 7 cycles apart.
        ts = -1; tr = -1; prev_s = s_n0; prev_r = r_n0;
        cmd_valid0 = 1'b1; cmd_set0 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (prev_s && !s_n0 && ts < 0) begin ts = cyc; cmd_set0 = 1'b0; end
            if (prev_r && !r_n0 && tr < 0) begin tr = cyc; cmd_valid0 = 1'b0; end
            prev_s = s_n0; prev_r = r_n0;
        end
        cmd_valid0 = 1'b0;
        check_eq("b2b_period", tr - ts, 7);
        wait_idle0();
        check_eq("b2b_state_q", sq0, 1'b0);

        // Direction flip during the pulse has no effect.
        issue0(1'b1);
        cmd_set0 = 1'b0;
        s_low = 0; r_low = 0;
        for (int i = 0; i < 10; i++) begin
            if (!s_n0) s_low++;
            if (!r_n0) r_low++;
            tick();
        end
        check_eq("flip_s_low_cycles", s_low, 4);
        check_eq("flip_r_low_cycles", r_low, 0);
        check_eq("flip_state_q", sq0, 1'b1);

        // Reset on the 2nd cycle of an r_n pulse truncates it.
        issue0(1'b0);
        tick();
        check_eq("rstmid_r_low_before", r_n0, 1'b0);
        rst_n = 1'b0;
        tick();
        check_eq("rstmid_r_n", r_n0, 1'b1);
        check_eq("rstmid_state_q", sq0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("rstmid_ready", rdy0, 1'b1);
        check_eq("rstmid_r_n_after", r_n0, 1'b1);

        // Short-pulse instance, valid held: 1-cycle pulses every P1+D1+1 cycles.
        falls = 0; s_low = 0; r_low = 0; t1 = -1; t2 = -1; prev_s = s_n1;
        cmd_valid1 = 1'b1; cmd_set1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (prev_s && !s_n1) begin
                falls++;
                if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc;
            end
            if (!s_n1) s_low++;
            if (!r_n1) r_low++;
            prev_s = s_n1;
        end
        cmd_valid1 = 1'b0;
        check_eq("short_period", t2 - t1, P1 + D1 + 1);
        check_eq("short_falls", falls, 11 / (P1 + D1 + 1) + 1);
        check_eq("short_low_cycles", s_low, falls);
        check_eq("short_r_low", r_low, 0);
        check_eq("short_state_q", sq1, 1'b1);

`ifdef SR_VERIFY_EN
        for (int i = 0; i < 20; i++) begin
            issue0(1'($urandom_range(0, 1)));
            wait_idle0();
        end
        check_eq("verify_err_clean", err0, 1'b0);
        check_eq("verify_err1_clean", err1, 1'b0);
        q_force = 1'b1;
        issue0(1'b1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("verify_err_before_idle", err0, 1'b0);
        tick();
        check_eq("verify_err_at_idle", err0, 1'b1);
        q_force = 1'b0;
        issue0(1'b1);
        wait_idle0();
        check_eq("verify_err_sticky", err0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("verify_err_cleared", err0, 1'b0);
`endif

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Synchronous command driver for an active-low SR NAND latch. It accepts set/reset commands through a valid/ready handshake and converts each one into a single active-low pulse on `s_n` or `r_n` of programmable width, followed by a programmable dead time. `s_n` and `r_n` are never low in the same cycle. The block sits between clocked control logic and the latch's asynchronous inputs, and keeps a shadow copy of the last commanded latch state.

## Interface
Parameters:
- `PULSE_W`, default 4: pulse length in clk cycles, minimum 1.
- `DEAD_T`, default 2: cycles with both outputs high after each pulse, minimum 1; minimum 2 when `SR_VERIFY_EN` is defined.
- `CW`, default 8: internal counter width. Must satisfy 2^CW > max(PULSE_W, DEAD_T).

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `cmd_valid`, input, 1: command present.
- `cmd_set`, input, 1: 1 = set the latch, 0 = reset it. Sampled only on acceptance.
- `cmd_ready`, output, 1: block can accept a command. Decoded from state IDLE.
- `s_n`, output, 1: active-low set pulse to the latch. Registered.
- `r_n`, output, 1: active-low reset pulse to the latch. Registered.
- `busy`, output, 1: high in PULSE and DEAD.
- `state_q`, output, 1: shadow of the last commanded latch value. Registered.
- `q`, input, 1: latch Q feedback. Present only with `SR_VERIFY_EN`.
- `err`, output, 1: sticky feedback mismatch flag. Present only with `SR_VERIFY_EN`.

## Operation
- FSM states are IDLE, PULSE and DEAD. The state encoding is internal.
- IDLE:
  - `cmd_ready`=1; `s_n`=`r_n`=1.
  - On `cmd_valid & cmd_ready` at a rising edge: capture `cmd_set` into `dir`, load counter with `PULSE_W-1`, go to PULSE.
  - At that same edge, drive `s_n`←0 if `dir`=1, else `r_n`←0.
- PULSE:
  - The selected output is held low and the other held high.
  - The counter decrements each cycle.
  - At the edge where counter=0: release the output (both ←1), update `state_q`←`dir`, load counter with `DEAD_T-1`, go to DEAD.
- DEAD:
  - Both outputs high; the counter decrements.
  - At the edge where counter=0, go to IDLE.
- `cmd_valid` is ignored outside IDLE, and commands are not queued. The upstream block holds `cmd_valid` until it sees ready.
- Changes on `cmd_set` after acceptance have no effect.
- A repeated command equal to `state_q` is still pulsed; there is no suppression.
- Invariant: `s_n | r_n` = 1 in every cycle, including during reset.
- Reset (`rst_n`=0 at an edge): state←IDLE, `s_n`=`r_n`=1, `state_q`=0, counter=0, `err`=0.
  - A pulse in progress is truncated at that edge and the command is dropped.
  - The physical latch is then undefined. Software issues a reset command to realign it with `state_q`.
- Reset values of outputs: `cmd_ready`=1, `s_n`=1, `r_n`=1, `busy`=0, `state_q`=0, `err`=0.

## Timing
- Acceptance edge E0: the pulse output goes low immediately after E0.
- The pulse output returns high at E0+`PULSE_W`; `state_q` updates at the same edge.
- `cmd_ready` rises at E0+`PULSE_W`+`DEAD_T`.
- The earliest next acceptance is edge E0+`PULSE_W`+`DEAD_T`+1, so command period = `PULSE_W`+`DEAD_T`+1 cycles.
- With defaults, the pulse is 4 cycles low, the dead time 2 cycles, and the period 7 cycles.
- `busy` = !`cmd_ready` in every cycle.

## Configuration
- `SR_VERIFY_EN` defined:
  - `q` passes through a 2-flop synchronizer.
  - At the DEAD→IDLE edge, the synchronized `q` is compared to `state_q`. On mismatch, `err`←1 and stays 1 until reset.
  - Ports `q` and `err` exist.
- `SR_VERIFY_EN` undefined: no synchronizer and no comparison logic; ports `q` and `err` are absent. All other behaviour is identical.

## Test plan
- **Single set:** after reset, `cmd_valid`=1, `cmd_set`=1 for 1 cycle → `s_n` low for exactly 4 cycles, `r_n` stays 1, `state_q`=1 after the pulse, `cmd_ready` low for 6 cycles.
- **Back-to-back:** `cmd_valid` held high with set then reset → pulses start 7 cycles apart; a checker confirms `s_n`,`r_n` are never both 0; `state_q` ends at 0.
- **Direction change mid-pulse:** flip `cmd_set` during PULSE → the pulse stays on the original output and its length is unchanged.
- **Reset mid-operation:** `rst_n`=0 on the 2nd cycle of an `r_n` pulse → `r_n`=1 after that edge, `state_q`=0, `cmd_ready`=1 after release.
- **Non-default parameters:** `PULSE_W`=1, `DEAD_T`=1 → 1-cycle pulse, period 3 cycles.
- **`SR_VERIFY_EN` checks:**
  - Behavioural NAND latch model wired back to `q` → `err` stays 0 over 20 random commands.
  - Same setup with `q` forced to 0 during a set → `err`=1 at the DEAD→IDLE edge and stays 1 until `rst_n` is asserted.
